// File: rtl/reaction_interval_meter_pkg.sv
// Shared types and constants for the reaction interval meter.
// The FSM encoding is also visible on the top-level debug port.
package reaction_interval_meter_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_FOUL = 3'd4,
    S_TMO  = 3'd5
  } state_t;

  localparam int          BCD_DIGITS = 4;
  localparam logic [15:0] BCD_MAX    = 16'h9999;

endpackage

// File: rtl/reaction_interval_meter_bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear and optional saturation.
// Each digit wraps from 9 to 0 and carries into the next digit.
module bcd_counter4
  import reaction_interval_meter_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        inc,
  input  logic        sat,
  output logic [15:0] value,
  output logic        at_max
);

  logic [15:0] value_inc;
  logic        carry;

  // Ripple carry: any digit at 9 or above rolls to 0, so no digit can exceed 9.
  always_comb begin
    value_inc = value;
    carry     = 1'b1;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (carry) begin
        if (value[4*i +: 4] >= 4'd9) begin
          value_inc[4*i +: 4] = 4'd0;
        end else begin
          value_inc[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign at_max = (value == BCD_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= 16'h0000;
    end else if (clear) begin
      value <= 16'h0000;
    end else if (inc && !(sat && at_max)) begin
      value <= value_inc;
    end
  end

endmodule

// File: rtl/reaction_interval_meter.sv
// Reaction timer core: pre-delay, stimulus lamp, then BCD ms count until the
// button rises. All status outputs are registered from the next state.
module reaction_interval_meter
  import reaction_interval_meter_pkg::*;
#(
  parameter int DELAY_MS = 2000,
  parameter int DLY_W    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ms_clk,
  input  logic        start,
  input  logic        button,
  output logic        stim_led,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        done,
  output logic        foul,
  output logic        timeout,
  output state_t      dbg_state
);

  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_MS - 1);

  state_t           state, state_nxt;
  logic [DLY_W-1:0] dly_cnt, dly_nxt;
  logic             ms_q, tick;
  logic             btn_s1, btn_s2, btn_s3, btn_rise;
  logic             cnt_clear, cnt_inc, cnt_at_max;

  assign tick      = ms_clk & ~ms_q;
  assign btn_rise  = btn_s2 & ~btn_s3;
  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ms_q   <= 1'b0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
    end else begin
      ms_q   <= ms_clk;
      btn_s1 <= button;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  // A button event always beats a coincident tick in WAIT and RUN.
  always_comb begin
    state_nxt = state;
    dly_nxt   = dly_cnt;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_WAIT: begin
        if (btn_rise) begin
          state_nxt = S_FOUL;
        end else if (tick) begin
          if (dly_cnt == DLY_LAST) state_nxt = S_RUN;
          else                     dly_nxt   = dly_cnt + DLY_W'(1);
        end
      end
      S_RUN: begin
        if (btn_rise) begin
          state_nxt = S_DONE;
        end else if (tick) begin
          if (cnt_at_max) state_nxt = S_TMO;
          else            cnt_inc   = 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_nxt = S_WAIT;
          dly_nxt   = '0;
          cnt_clear = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      dly_cnt  <= '0;
      stim_led <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      foul     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      dly_cnt  <= dly_nxt;
      stim_led <= (state_nxt == S_RUN);
      busy     <= (state_nxt == S_WAIT) || (state_nxt == S_RUN);
      done     <= (state_nxt == S_DONE);
      foul     <= (state_nxt == S_FOUL);
      timeout  <= (state_nxt == S_TMO);
    end
  end

  bcd_counter4 u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .sat    (1'b1),
    .value  (bcd),
    .at_max (cnt_at_max)
  );

endmodule
